// File: rtl/pos_pkg.sv
// rtl/pos_pkg.sv - shared widths, state encoding and saturation helper for pos_arbiter
//
// Purpose : common definitions for the frame-synchronous position arbiter.
// Contents: POS_W        coordinate width (12 bits)
//           pos_state_e  arbiter FSM state encoding (IDLE / OWN_A / OWN_B)
//           pos_src_e    identity of the most recently granted source
//           pos_sat()    optional upper-bound saturation of a coordinate
package pos_pkg;

    localparam int POS_W = 12;

    // One bit per owning source, so each grant is a single state bit.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } pos_state_e;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } pos_src_e;

    // Returns lim when saturation is enabled and v exceeds it, else v untouched.
    function automatic logic [POS_W-1:0] pos_sat(
        input logic [POS_W-1:0] v,
        input logic [POS_W-1:0] lim,
        input logic             en
    );
        return (en && (v > lim)) ? lim : v;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick, purely combinational
//
// Purpose : chooses between two requesters, favouring the one that did not
//           win most recently when both request.
// Ports   : req_a  in  request from source A
//           req_b  in  request from source B
//           last   in  1 = source B won most recently, 0 = source A did
//           pick_a out source A selected (never together with pick_b)
//           pick_b out source B selected
module rr_arb2 (
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    output logic pick_a,
    output logic pick_b
);

    // A lone requester always wins; under contention the previous loser wins.
    assign pick_a = req_a & (~req_b |  last);
    assign pick_b = req_b & (~req_a | ~last);

endmodule

// File: rtl/pos_arbiter.sv
// rtl/pos_arbiter.sv - frame-synchronous arbiter between two position sources
//
// Purpose : at each rising edge of vblnk, grants the position path to source A
//           or B (round-robin under contention) and latches that source's
//           coordinates; grant and coordinates then stay fixed for the frame.
// Config  : define POS_CLAMP_EN to saturate latched x/y to XMAX/YMAX.
// Params  : XMAX, YMAX  largest legal x / y coordinate
// Ports   : pclk                 in  clock, all state changes on rising edge
//           rst                  in  asynchronous active-high reset
//           vblnk                in  vertical blanking level (pclk domain)
//           req_a, req_b         in  position-path requests from A and B
//           xpos_a, ypos_a       in  candidate coordinates from A
//           xpos_b, ypos_b       in  candidate coordinates from B
//           gnt_a, gnt_b         out registered grants, mutually exclusive
//           xpos_out, ypos_out   out latched frame-stable position
//           pos_valid            out one-cycle pulse when a position is latched
module pos_arbiter
    import pos_pkg::*;
#(
    parameter int XMAX = 799,
    parameter int YMAX = 599
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             vblnk,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [POS_W-1:0] xpos_a,
    input  logic [POS_W-1:0] ypos_a,
    input  logic [POS_W-1:0] xpos_b,
    input  logic [POS_W-1:0] ypos_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic [POS_W-1:0] xpos_out,
    output logic [POS_W-1:0] ypos_out,
    output logic             pos_valid
);

`ifdef POS_CLAMP_EN
    localparam logic CLAMP_EN = 1'b1;
`else
    localparam logic CLAMP_EN = 1'b0;
`endif

    localparam logic [POS_W-1:0] XLIM = POS_W'(XMAX);
    localparam logic [POS_W-1:0] YLIM = POS_W'(YMAX);

    pos_state_e       state_q;
    pos_src_e         last_q;
    logic             vblnk_q;
    logic             pos_valid_q;
    logic [POS_W-1:0] xpos_q;
    logic [POS_W-1:0] ypos_q;

    logic             frame_edge;
    logic             pick_a;
    logic             pick_b;
    logic [POS_W-1:0] xpos_a_d;
    logic [POS_W-1:0] ypos_a_d;
    logic [POS_W-1:0] xpos_b_d;
    logic [POS_W-1:0] ypos_b_d;

    // vblnk_q resets high, so a blanking level already present at reset
    // release is not mistaken for a new frame.
    assign frame_edge = vblnk & ~vblnk_q;

    rr_arb2 u_rr_arb2 (
        .req_a  (req_a),
        .req_b  (req_b),
        .last   (last_q == SRC_B),
        .pick_a (pick_a),
        .pick_b (pick_b)
    );

    assign xpos_a_d = pos_sat(xpos_a, XLIM, CLAMP_EN);
    assign ypos_a_d = pos_sat(ypos_a, YLIM, CLAMP_EN);
    assign xpos_b_d = pos_sat(xpos_b, XLIM, CLAMP_EN);
    assign ypos_b_d = pos_sat(ypos_b, YLIM, CLAMP_EN);

    // Arbitration happens only on a frame edge; between edges the owner is
    // held regardless of its request, and coordinates are frozen.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= SRC_B;
            vblnk_q     <= 1'b1;
            pos_valid_q <= 1'b0;
            xpos_q      <= '0;
            ypos_q      <= '0;
        end else begin
            vblnk_q     <= vblnk;
            pos_valid_q <= 1'b0;
            if (frame_edge) begin
                if (pick_a) begin
                    state_q     <= OWN_A;
                    last_q      <= SRC_A;
                    xpos_q      <= xpos_a_d;
                    ypos_q      <= ypos_a_d;
                    pos_valid_q <= 1'b1;
                end else if (pick_b) begin
                    state_q     <= OWN_B;
                    last_q      <= SRC_B;
                    xpos_q      <= xpos_b_d;
                    ypos_q      <= ypos_b_d;
                    pos_valid_q <= 1'b1;
                end else begin
                    // No requester: release the path, keep the old position.
                    state_q     <= IDLE;
                end
            end
        end
    end

    // Each grant is a single bit of the state register (one-hot encoding).
    assign gnt_a     = state_q[0];
    assign gnt_b     = state_q[1];
    assign xpos_out  = xpos_q;
    assign ypos_out  = ypos_q;
    assign pos_valid = pos_valid_q;

endmodule

// File: doc/pos_arbiter.md
POS_ARBITER -- requirements
Module: pos_arbiter

Interface
REQ-001 SHALL have parameter XMAX, default 799: largest legal x coordinate.
REQ-002 SHALL have parameter YMAX, default 599: largest legal y coordinate.
REQ-003 SHALL have port pclk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port vblnk, input, 1: vertical blanking level, pclk-synchronous.
REQ-006 SHALL have ports req_a and req_b, input, 1 each: source A (mouse) and source B (demo/auto-aim) request the position path.
REQ-007 SHALL have ports xpos_a, ypos_a, xpos_b, ypos_b, input, 12 each: unsigned candidate coordinates.
REQ-008 SHALL have ports gnt_a and gnt_b, output, 1 each: registered grants, never both high.
REQ-009 SHALL have ports xpos_out and ypos_out, output, 12 each: registered, frame-stable position.
REQ-010 SHALL have port pos_valid, output, 1: one-cycle pulse when a new position is latched.

Function
REQ-011 SHALL detect frame start as vblnk high in cycle N while the registered vblnk copy is low ("edge in cycle N").
REQ-012 SHALL evaluate arbitration only in an edge cycle; grants, xpos_out and ypos_out SHALL be unchanged in all other cycles.
REQ-013 SHALL use FSM states IDLE, OWN_A and OWN_B; reset state is IDLE, with gnt_a/gnt_b equal to (state==OWN_A)/(state==OWN_B).
REQ-014 SHALL, on an edge with only req_a high, go to OWN_A; with only req_b high, go to OWN_B; with neither, go to IDLE.
REQ-015 SHALL, on an edge with both requests high, grant the source not granted most recently (round-robin); last-winner register resets to B, so A wins first contention.
REQ-016 SHALL hold the grant for the whole frame even if the owner drops its request; a request change takes effect only at the next edge.
REQ-017 SHALL, on an edge that grants a source, load xpos_out/ypos_out from that source's inputs sampled in cycle N and assert pos_valid in cycle N+1 only (latency 1).
REQ-018 SHALL, on an edge resulting in IDLE, keep xpos_out/ypos_out at previous values and not assert pos_valid.
REQ-019 SHALL update the last-winner register only when a grant is issued.
REQ-020 SHALL treat vblnk high at reset release as already-seen (registered copy resets high) so no spurious edge occurs.

Reset
REQ-021 SHALL, while rst is high, force state IDLE, gnt_a=gnt_b=0, xpos_out=ypos_out=0, pos_valid=0, last-winner=B, vblnk copy=1, independent of pclk.
REQ-022 SHALL, when reset is asserted mid-frame, drop any grant immediately and resume arbitration at the first edge after release.

Configuration
REQ-023 SHALL, with macro POS_CLAMP_EN defined, saturate the latched x to XMAX and y to YMAX when the input exceeds them.
REQ-024 SHALL, without POS_CLAMP_EN, latch the granted coordinates unmodified.

Structure
REQ-025 SHALL take POS_W (12) and the FSM state encoding from shared package pos_pkg.
REQ-026 SHALL place two-way round-robin selection in sub-module rr_arb2 (inputs req_a, req_b, last; outputs pick_a, pick_b); edge detect, FSM and output registers stay in pos_arbiter.

Verification
REQ-027 SHALL test: req_a=1, req_b=0, xpos_a=100, ypos_a=200, vblnk 0->1 -> gnt_a=1 and out=(100,200) next cycle, pos_valid one cycle.
REQ-028 SHALL test: both requests held over three edges -> grants A, B, A in turn.
REQ-029 SHALL test: owner A drops req_a mid-frame -> gnt_a stays 1 until next edge, then IDLE, outputs held, no pos_valid.
REQ-030 SHALL test: POS_CLAMP_EN defined, xpos_b=1000, ypos_b=700 granted -> out=(799,599); undefined -> out=(1000,700).
REQ-031 SHALL test: rst asserted mid-frame between clock edges -> grants and outputs 0 immediately; vblnk high at release -> no pos_valid until a fresh 0->1.
